// File: rtl/upp_ctrl_pkg.sv
// upp_ctrl_pkg: shared state encoding, mode codes and default cycle constants for the UPP link controller
package upp_ctrl_pkg;
  typedef enum logic [2:0] {OFF, HOLD_RST, SETTLE, RUN, BLANK, ALIGN} state_t;
  localparam logic MODE_20M = 1'b0;
  localparam logic MODE_40K = 1'b1;
  localparam int BLANK_CYC_D = 16;
  localparam int RST_CYC_D = 8;
  localparam int SETTLE_CYC_D = 64;
  localparam int DIV_PERIOD_D = 1000;
  localparam int RX_TIMEOUT_D = 4000;
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/upp_link_ctrl_if.sv
// upp_link_ctrl_if: config/datapath bundle; slave = controller (tx_en, mode_req, mode_req_vld, rx_valid, err_clr in; sel, tx_blank, link_rst, busy, mode_ack, mode_nack, link_up, timeout_err out), master = driver side
interface upp_link_ctrl_if;
  logic tx_en;
  logic mode_req;
  logic mode_req_vld;
  logic rx_valid;
  logic err_clr;
  logic sel;
  logic tx_blank;
  logic link_rst;
  logic busy;
  logic mode_ack;
  logic mode_nack;
  logic link_up;
  logic timeout_err;
  modport slave (
    input tx_en, mode_req, mode_req_vld, rx_valid, err_clr,
    output sel, tx_blank, link_rst, busy, mode_ack, mode_nack, link_up, timeout_err
  );
  modport master (
    output tx_en, mode_req, mode_req_vld, rx_valid, err_clr,
    input sel, tx_blank, link_rst, busy, mode_ack, mode_nack, link_up, timeout_err
  );
endinterface

// File: rtl/upp_cycle_timer.sv
// upp_cycle_timer: loadable down-counter shared by timed states; ports clk_40m, cfg_rst_n, load, load_val in; value, done (value==0) out
module upp_cycle_timer #(
  parameter int W = 6
) (
  input  logic         clk_40m,
  input  logic         cfg_rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         done
);
  always_ff @(posedge clk_40m or negedge cfg_rst_n)
    if (!cfg_rst_n) value <= '0;
    else value <= load ? load_val : (value != '0) ? value - 1'b1 : value;
  assign done = value == '0;
endmodule

// File: rtl/upp_link_ctrl.sv
// upp_link_ctrl: UPP/EMIF link sequencer (rate select, datapath reset, TX blanking, rx watchdog); ports clk_40m, cfg_rst_n, lnk (slave modport)
module upp_link_ctrl
  import upp_ctrl_pkg::*;
#(
  parameter int BLANK_CYC  = BLANK_CYC_D,
  parameter int RST_CYC    = RST_CYC_D,
  parameter int SETTLE_CYC = SETTLE_CYC_D,
  parameter int DIV_PERIOD = DIV_PERIOD_D,
  parameter int RX_TIMEOUT = RX_TIMEOUT_D
) (
  input  logic            clk_40m,
  input  logic            cfg_rst_n,
  upp_link_ctrl_if.slave  lnk
);
  localparam int TW = $clog2(max3(BLANK_CYC, RST_CYC, SETTLE_CYC));
  localparam int PW = $clog2(DIV_PERIOD);
  localparam int WW = $clog2(RX_TIMEOUT);
  state_t state, state_nxt;
  logic [TW-1:0] t_load_val, t_val_unused;
  logic [PW-1:0] phase;
  logic [WW-1:0] wd;
  logic t_load, t_done, pend, pend_mode, rx_m, rx_s;
  logic req_sw, req_same, req_rej, ack_settle, wd_clr, wd_set;
  upp_cycle_timer #(.W(TW)) u_tmr (
    .clk_40m   (clk_40m),
    .cfg_rst_n (cfg_rst_n),
    .load      (t_load),
    .load_val  (t_load_val),
    .value     (t_val_unused),
    .done      (t_done)
  );
  always_ff @(posedge clk_40m or negedge cfg_rst_n)
    if (!cfg_rst_n) state <= OFF;
    else state <= state_nxt;
  always_comb begin
    req_sw = lnk.mode_req_vld && lnk.tx_en && state == RUN && lnk.mode_req != lnk.sel;
    req_same = lnk.mode_req_vld && lnk.tx_en && state == RUN && lnk.mode_req == lnk.sel;
    req_rej = lnk.mode_req_vld && !(lnk.tx_en && state == RUN);
    state_nxt = state;
    if (!lnk.tx_en) state_nxt = OFF;
    else
      case (state)
        OFF:      state_nxt = HOLD_RST;
        HOLD_RST: state_nxt = t_done ? SETTLE : HOLD_RST;
        SETTLE:   state_nxt = t_done ? RUN : SETTLE;
        RUN:      state_nxt = req_sw ? BLANK : RUN;
        BLANK:    state_nxt = t_done ? ALIGN : BLANK;
        ALIGN:    state_nxt = (phase == PW'(DIV_PERIOD - 1)) ? HOLD_RST : ALIGN;
        default:  state_nxt = OFF;
      endcase
    ack_settle = state == SETTLE && state_nxt == RUN && pend;
    t_load = state_nxt != state;
    t_load_val = (state_nxt == HOLD_RST) ? TW'(RST_CYC - 1) :
                 (state_nxt == SETTLE)   ? TW'(SETTLE_CYC - 1) :
                 (state_nxt == BLANK)    ? TW'(BLANK_CYC - 1) : '0;
  end
  always_comb begin
    lnk.tx_blank = state != RUN;
    lnk.link_rst = state == OFF || state == HOLD_RST;
    lnk.busy = !(state == OFF || state == RUN);
    lnk.link_up = state == RUN && !lnk.timeout_err;
  end
  always_ff @(posedge clk_40m or negedge cfg_rst_n)
    if (!cfg_rst_n) begin
      lnk.sel <= MODE_20M;
      pend <= 1'b0;
      pend_mode <= MODE_20M;
      lnk.mode_ack <= 1'b0;
      lnk.mode_nack <= 1'b0;
    end else begin
      lnk.mode_ack <= req_same || ack_settle;
      lnk.mode_nack <= req_rej;
      pend <= req_sw ? 1'b1 : (state_nxt == OFF || ack_settle) ? 1'b0 : pend;
      pend_mode <= req_sw ? lnk.mode_req : pend_mode;
      lnk.sel <= (state == ALIGN && state_nxt == HOLD_RST) ? pend_mode : lnk.sel;
    end
  // phase is held at 0 during link_rst so it restarts in step with the datapath dividers
  always_ff @(posedge clk_40m or negedge cfg_rst_n)
    if (!cfg_rst_n) phase <= '0;
    else phase <= (lnk.link_rst || phase == PW'(DIV_PERIOD - 1)) ? '0 : phase + 1'b1;
  always_comb begin
    wd_clr = rx_s || lnk.err_clr || state != RUN;
    wd_set = state == RUN && !rx_s && wd == WW'(RX_TIMEOUT - 1);
  end
  // set is independent of err_clr so a coincident clear loses
  always_ff @(posedge clk_40m or negedge cfg_rst_n)
    if (!cfg_rst_n) begin
      rx_m <= 1'b0;
      rx_s <= 1'b0;
      wd <= '0;
      lnk.timeout_err <= 1'b0;
    end else begin
      rx_m <= lnk.rx_valid;
      rx_s <= rx_m;
      wd <= (wd_clr || wd == WW'(RX_TIMEOUT - 1)) ? '0 : wd + 1'b1;
      lnk.timeout_err <= wd_set ? 1'b1 : lnk.err_clr ? 1'b0 : lnk.timeout_err;
    end
endmodule
